// File: rtl/scan_shift_ctrl.sv
// scan_shift_ctrl: serially launches a parallel pattern into an external DFF scan chain.
// It also unloads the previous chain contents, then issues a one-cycle capture strobe.
module scan_shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             VALID,
    input  logic [WIDTH-1:0] DIN,
    output logic             READY,
    output logic             SE,
    output logic             SO,
    input  logic             SI,
    output logic             CAP,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] dout_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shifted_s;
    logic             last_s;

    // Outgoing bit leaves the MSB while the chain tail enters the LSB.
    assign shifted_s = {sreg_r[WIDTH-2:0], SI};
    assign last_s    = (cnt_r == CNT_LAST);
    assign DOUT      = dout_r;

    // Controller state register
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and output decode from registered state
    always_comb begin
        state_s    = state_r;
        READY      = 1'b0;
        SE         = 1'b0;
        SO         = 1'b0;
        CAP        = 1'b0;
        DOUT_VALID = 1'b0;
        case (state_r)
            ST_IDLE: begin
                READY = 1'b1;
                if (VALID) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                SE = 1'b1;
                SO = sreg_r[WIDTH-1];
                if (last_s) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                CAP        = 1'b1;
                DOUT_VALID = 1'b1;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pattern/response shift register, bit counter and unload register
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            sreg_r <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            dout_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (VALID) begin
                        sreg_r <= DIN;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    sreg_r <= shifted_s;
                    cnt_r  <= cnt_r + CW'(1);
                    // Final shift edge: the response is complete, including this SI bit.
                    if (last_s) begin
                        dout_r <= shifted_s;
                    end
                end
                default: begin
                    sreg_r <= sreg_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Bench for scan_shift_ctrl: 8-flop chain model that complements on CAP, random patterns,
// and a scoreboard fed at accept time and drained when the DUT presents SO/DOUT.
module tb_scan_shift_ctrl;

    localparam int W = 8;

    logic         CLK   = 1'b0;
    logic         R     = 1'b0;
    logic         VALID = 1'b0;
    logic [W-1:0] DIN   = 8'h00;
    logic         SI;
    logic         READY;
    logic         SE;
    logic         SO;
    logic         CAP;
    logic [W-1:0] DOUT;
    logic         DOUT_VALID;

    logic [W-1:0] chain = 8'h00;
    int           cyc   = 0;
    int           checks = 0;
    int           errors = 0;

    scan_shift_ctrl #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .R          (R),
        .VALID      (VALID),
        .DIN        (DIN),
        .READY      (READY),
        .SE         (SE),
        .SO         (SO),
        .SI         (SI),
        .CAP        (CAP),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID)
    );

    always #5 CLK = ~CLK;

    // External chain: chain[0] is the head, chain[W-1] the tail feeding SI.
    assign SI = chain[W-1];
    always @(posedge CLK) begin
        if (SE) chain <= {chain[W-2:0], SO};
        else if (CAP) chain <= ~chain;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: transaction-level view of the controller and chain
    int           acc_t    = 0;
    bit           have     = 1'b0;
    int           free_cyc = 0;
    int           acc_cnt  = 0;
    logic [W-1:0] chain_ref = 8'h00;
    logic [W-1:0] dout_hold = 8'h00;
    bit           prev_cap = 1'b0;
    bit           so_q[$];
    logic [W-1:0] dout_q[$];
    logic [W-1:0] pat_q[$];

    // Monitor: per-cycle control checks plus scoreboard drains on SE / DOUT_VALID
    always @(negedge CLK) begin
        bit           exp_ready;
        bit           exp_se;
        bit           exp_cap;
        bit           b;
        logic [W-1:0] e;
        logic [W-1:0] p;
        if (!R) begin
            have = 1'b0;
            free_cyc = 0;
            so_q.delete();
            dout_q.delete();
            pat_q.delete();
            dout_hold = 8'h00;
            chain_ref = chain;
        end
        exp_ready = (cyc >= free_cyc);
        exp_se    = have && (cyc >= acc_t) && (cyc <= acc_t + W - 1);
        exp_cap   = have && (cyc == acc_t + W);
        chk("ready", READY, exp_ready);
        chk("se", SE, exp_se);
        chk("cap", CAP, exp_cap);
        chk("dout_valid", DOUT_VALID, exp_cap);
        chk("cap_single_pulse", CAP & prev_cap, 1'b0);
        prev_cap = CAP;
        if (SE) begin
            if (so_q.size() == 0) chk("so_unexpected", 1'b1, 1'b0);
            else begin
                b = so_q.pop_front();
                chk("so", SO, b);
            end
        end else begin
            chk("so_idle", SO, 1'b0);
        end
        if (DOUT_VALID) begin
            if (dout_q.size() == 0) chk("dout_unexpected", 1'b1, 1'b0);
            else begin
                e = dout_q.pop_front();
                p = pat_q.pop_front();
                chk("dout", DOUT, e);
                chk("chain_loaded", chain, p);
                dout_hold = e;
            end
        end
        chk("dout_hold", DOUT, dout_hold);
        if (R && VALID && exp_ready) begin
            acc_t    = cyc + 1;
            have     = 1'b1;
            free_cyc = acc_t + W + 1;
            for (int k = 0; k < W; k++) so_q.push_back(DIN[W-1-k]);
            dout_q.push_back(chain_ref);
            pat_q.push_back(DIN);
            chain_ref = ~DIN;
            acc_cnt++;
        end
    end

    task automatic reset_now();
        @(posedge CLK);
        #3;
        R = 1'b0;
        #1;
        chk("rst_ready", READY, 1'b1);
        chk("rst_se", SE, 1'b0);
        chk("rst_so", SO, 1'b0);
        chk("rst_cap", CAP, 1'b0);
        chk("rst_dout", DOUT, 8'h00);
        chk("rst_dout_valid", DOUT_VALID, 1'b0);
        @(posedge CLK);
        #3;
        R = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit noise);
        int n;
        bit ok;
        @(posedge CLK);
        #1;
        DIN   = d;
        VALID = 1'b1;
        n     = acc_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (acc_cnt != n) ok = 1'b1;
        end
        VALID = 1'b0;
        chk("accept_timeout", ok, 1'b1);
        if (noise) begin
            for (int i = 0; i < W - 1; i++) begin
                DIN   = W'($urandom);
                VALID = 1'($urandom_range(0, 1));
                @(posedge CLK);
                #1;
            end
            VALID = 1'b0;
            DIN   = W'($urandom);
        end
    endtask

    initial begin
        int n;
        bit ok;
        repeat (2) @(posedge CLK);
        #3;
        R = 1'b1;
        repeat (2) @(posedge CLK);
        reset_now();
        // Single pattern from a cleared chain, then a second one unloading 0x5A
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b0);
        // Back-to-back with VALID held high for three accepts
        @(posedge CLK);
        #1;
        VALID = 1'b1;
        DIN   = W'($urandom);
        n     = acc_cnt;
        ok    = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge CLK);
            #1;
            DIN = W'($urandom);
            if (acc_cnt == n + 3) ok = 1'b1;
        end
        VALID = 1'b0;
        chk("b2b_timeout", ok, 1'b1);
        // Abort during shift cycle 4, then an all-ones pattern
        send(W'($urandom), 1'b0);
        repeat (2) @(posedge CLK);
        reset_now();
        send(8'hFF, 1'b0);
        send(W'($urandom), 1'b1);
        // Random patterns, gaps and in-shift VALID/DIN noise
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            send(W'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (15) @(posedge CLK);
        #1;
        chk("so_queue_drained", so_q.size(), 0);
        chk("dout_queue_drained", dout_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
